pc_seq: RTL and testbench
=========================

// Module: pc_seq
// PURPOSE
//  Fetch sequencer and sole driver of the pc block's branch/increment/bra_add inputs.
//  Loads reset/NMI/IRQ vectors and fetches opcode/operand bytes at pc_addr over a req/ack memory port.
//  Hands fetched bytes to the decoder through a valid/ready port.
//  Applies absolute jumps and signed 8-bit relative branches requested by execute.
// PARAMETERS
//  AW       16       address width (pc width)
//  RST_VEC  16'hFFFC reset vector address (lo byte; hi byte at +1)
//  NMI_VEC  16'hFFFA NMI vector address
//  IRQ_VEC  16'hFFFE IRQ vector address
// PORTS
//  clk         in   1   system clock; only clock in the block
//  rst         in   1   synchronous, active-high reset
//  pc_addr     in   AW  current pc value from pc block
//  branch      out  1   pc load strobe (1 cycle)
//  increment   out  1   pc +1 strobe (1 cycle)
//  bra_add     out  AW  pc load value, valid while branch=1
//  mem_req     out  1   memory read request
//  mem_addr    out  AW  read address, stable while mem_req=1
//  mem_ack     in   1   read done; mem_data valid this cycle
//  mem_data    in   8   read data
//  op_valid    out  1   fetched byte available
//  op_byte     out  8   fetched byte
//  op_ready    in   1   decoder accepts op_byte (transfer when valid & ready)
//  jmp_req     in   1   absolute jump request, 1-cycle pulse
//  jmp_target  in   AW  jump target
//  rel_req     in   1   relative branch request, 1-cycle pulse
//  rel_off     in   8   signed branch offset
//  nmi         in   1   non-maskable interrupt, rising-edge sensitive
//  irq         in   1   interrupt, level sensitive
//  irq_mask    in   1   1 = irq ignored
//  vec_busy    out  1   vector sequence in progress
// BEHAVIOUR
//  Reset: all outputs 0, buffer empty, nmi edge latch cleared. First cycle after rst=0 enters VEC_LO.
//  FSM states:
//   - IDLE, REQ, VEC_LO, VEC_HI, VEC_LD.
//   - VEC_LO: req at vec; ack captures lo -> VEC_HI.
//   - VEC_HI: req at vec+1; ack captures hi -> VEC_LD.
//   - VEC_LD: branch=1, bra_add={hi,lo}, 1 cycle -> IDLE.
//   - vec_busy=1 in VEC_*.
//  Fetch: IDLE issues req (mem_addr=pc_addr) when buffer has room and no jump, vector or interrupt is pending -> REQ.
//   - mem_req/mem_addr held until mem_ack.
//   - Cycle after ack: op_valid=1, op_byte=data, increment=1 (exactly 1 cycle) -> IDLE.
//   - mem_req is low for >=1 cycle after every ack, so the next address sees the updated pc.
//  Redirect (jmp_req or rel_req):
//   - Applies in IDLE: branch=1 next cycle; bra_add=jmp_target, or pc_addr+sext(rel_off) mod 2^AW (FFFF+1=0000, 0000-1=FFFF).
//   - Buffer flushed (op_valid=0) in the same cycle.
//   - If received in REQ: latched; ack completes, data discarded, no increment; redirect then applied.
//   - Ignored while vec_busy=1.
//   - jmp_req and rel_req together: jmp wins.
//  Interrupts: sampled in IDLE only, when buffer is empty (instruction boundary) and no redirect is pending.
//   - nmi edge has priority over irq&~irq_mask.
//   - Taken -> VEC_LO with that vector; nmi latch cleared on entry.
//  Priority: rst > redirect > nmi > irq > fetch.
//  branch and increment are never high in the same cycle.
//  op_byte holds its value while op_valid=1 and op_ready=0.
// CONFIGURATION
//  PC_SEQ_PREFETCH_EN defined:
//   - 2-entry FIFO op buffer; a fetch may issue while one byte is waiting; order is preserved.
//   - Redirect flushes both entries.
//   - Interrupts still require an empty buffer.
//  PC_SEQ_PREFETCH_EN undefined:
//   - 1-entry buffer; no req while op_valid=1.
// TESTING
//  1. Reset: rst 2 cycles; mem returns FC->34, FD->12, 1-cycle ack.
//     -> branch=1 with bra_add=16'h1234 once; then mem_req at 1234.
//  2. Fetch with backpressure: pc=1234, ack data A9, op_ready=0 for 3 cycles.
//     -> op_byte=A9 held; single increment pulse; no new req until accept (without PREFETCH).
//  3. Relative wrap: pc=FFF0, rel_off=8'h20 -> bra_add=0010. Then pc=0005, rel_off=8'hF0 -> bra_add=FFF5.
//  4. Jump mid-fetch: jmp_req(target C000) while req pending 3 cycles.
//     -> req holds to ack; data dropped; no increment; branch=1 with C000; next req at C000.
//  5. Interrupts: irq=1, irq_mask=0 with nmi rising in the same cycle.
//     -> vector read at FFFA/FFFB; irq vector only after NMI load, if irq still high.
//  6. With PC_SEQ_PREFETCH_EN: op_ready=0, two acks (11,22).
//     -> 11 then 22 delivered in order; third req withheld until an entry frees.

Source files
------------

// File: rtl/pc_seq.sv
// pc_seq: fetch sequencer owning pc load/increment, vector loads and the op buffer.
// Define PC_SEQ_PREFETCH_EN for a 2-entry prefetch buffer (default: 1 entry).
module pc_seq #(
    parameter int            AW      = 16,
    parameter logic [AW-1:0] RST_VEC = AW'(16'hFFFC),
    parameter logic [AW-1:0] NMI_VEC = AW'(16'hFFFA),
    parameter logic [AW-1:0] IRQ_VEC = AW'(16'hFFFE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_addr,
    output logic          branch,
    output logic          increment,
    output logic [AW-1:0] bra_add,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_data,
    output logic          op_valid,
    output logic [7:0]    op_byte,
    input  logic          op_ready,
    input  logic          jmp_req,
    input  logic [AW-1:0] jmp_target,
    input  logic          rel_req,
    input  logic [7:0]    rel_off,
    input  logic          nmi,
    input  logic          irq,
    input  logic          irq_mask,
    output logic          vec_busy
);

`ifdef PC_SEQ_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    typedef enum logic [2:0] {IDLE, REQ, VEC_LO, VEC_HI, VEC_LD} state_t;

    state_t        state_q, state_d;
    logic          boot_q, boot_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    lo_q, lo_d, hi_q, hi_d;
    logic          rbr_q, rbr_d;
    logic [AW-1:0] rtgt_q, rtgt_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] ptgt_q, ptgt_d;
    logic          inc_q, inc_d;
    logic          nmi_prev_q, nmi_lat_q, nmi_lat_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [7:0]    b0_q, b0_d, b1_q, b1_d;

    logic          redir, nmi_edge, nmi_pend, int_ok, room;
    logic          push, pop, flush, clr_nmi;
    logic [1:0]    idx;
    logic [AW-1:0] redir_tgt;

    assign redir     = jmp_req | rel_req;
    assign redir_tgt = jmp_req ? jmp_target
                     : pc_addr + {{(AW-8){rel_off[7]}}, rel_off};
    assign nmi_edge  = nmi & ~nmi_prev_q;
    assign nmi_pend  = nmi_lat_q | nmi_edge;
    // Interrupts only at an instruction boundary with the pc settled
    assign int_ok    = (cnt_q == 2'd0) & ~rbr_q;
    assign room      = cnt_q < DEPTH;

    always_comb begin
        state_d = state_q;
        boot_d  = boot_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        rbr_d   = 1'b0;
        rtgt_d  = rtgt_q;
        pend_d  = pend_q;
        ptgt_d  = ptgt_q;
        inc_d   = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        clr_nmi = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (boot_q) begin
                    state_d = VEC_LO;
                    addr_d  = RST_VEC;
                    boot_d  = 1'b0;
                end else if (redir) begin
                    rbr_d  = 1'b1;
                    rtgt_d = redir_tgt;
                    flush  = 1'b1;
                end else if (int_ok && nmi_pend) begin
                    state_d = VEC_LO;
                    addr_d  = NMI_VEC;
                    clr_nmi = 1'b1;
                end else if (int_ok && irq && !irq_mask) begin
                    state_d = VEC_LO;
                    addr_d  = IRQ_VEC;
                end else if (room && !rbr_q && !inc_q) begin
                    state_d = REQ;
                    addr_d  = pc_addr;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                    if (pend_q || redir) begin
                        rbr_d  = 1'b1;
                        rtgt_d = redir ? redir_tgt : ptgt_q;
                        flush  = 1'b1;
                    end else begin
                        push  = 1'b1;
                        inc_d = 1'b1;
                    end
                end else if (redir) begin
                    pend_d = 1'b1;
                    ptgt_d = redir_tgt;
                end
            end
            VEC_LO: begin
                if (mem_ack) begin
                    lo_d    = mem_data;
                    addr_d  = addr_q + AW'(1);
                    state_d = VEC_HI;
                end
            end
            VEC_HI: begin
                if (mem_ack) begin
                    hi_d    = mem_data;
                    state_d = VEC_LD;
                end
            end
            VEC_LD:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign nmi_lat_d = clr_nmi ? 1'b0 : nmi_pend;
    assign pop       = op_valid & op_ready;
    assign idx       = cnt_q - {1'b0, pop};

    always_comb begin
        b0_d  = b0_q;
        b1_d  = b1_q;
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            if (pop) b0_d = b1_q;
            if (push) begin
                if (idx == 2'd0) b0_d = mem_data;
                else             b1_d = mem_data;
            end
            cnt_d = idx + {1'b0, push};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            boot_q     <= 1'b1;
            addr_q     <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            rbr_q      <= 1'b0;
            rtgt_q     <= '0;
            pend_q     <= 1'b0;
            ptgt_q     <= '0;
            inc_q      <= 1'b0;
            nmi_prev_q <= 1'b0;
            nmi_lat_q  <= 1'b0;
            cnt_q      <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
        end else begin
            state_q    <= state_d;
            boot_q     <= boot_d;
            addr_q     <= addr_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            rbr_q      <= rbr_d;
            rtgt_q     <= rtgt_d;
            pend_q     <= pend_d;
            ptgt_q     <= ptgt_d;
            inc_q      <= inc_d;
            nmi_prev_q <= nmi;
            nmi_lat_q  <= nmi_lat_d;
            cnt_q      <= cnt_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
        end
    end

    assign vec_busy  = (state_q == VEC_LO) | (state_q == VEC_HI)
                     | (state_q == VEC_LD);
    assign branch    = rbr_q | (state_q == VEC_LD);
    assign bra_add   = (state_q == VEC_LD) ? AW'({hi_q, lo_q})
                     : (rbr_q ? rtgt_q : '0);
    assign increment = inc_q;
    assign mem_req   = (state_q == REQ) | (state_q == VEC_LO)
                     | (state_q == VEC_HI);
    assign mem_addr  = addr_q;
    assign op_valid  = cnt_q != 2'd0;
    assign op_byte   = b0_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed bench for pc_seq with a pc model and a req/ack memory.
// Honours PC_SEQ_PREFETCH_EN to select the matching expectations.
module tb_pc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        branch, increment, mem_req, op_valid, vec_busy;
    logic [15:0] bra_add, mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic [7:0]  op_byte;
    logic        op_ready, jmp_req, rel_req, nmi, irq, irq_mask;
    logic [15:0] jmp_target;
    logic [7:0]  rel_off;

    always #5 clk = ~clk;

    pc_seq dut (
        .clk(clk), .rst(rst), .pc_addr(pc),
        .branch(branch), .increment(increment), .bra_add(bra_add),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data),
        .op_valid(op_valid), .op_byte(op_byte), .op_ready(op_ready),
        .jmp_req(jmp_req), .jmp_target(jmp_target),
        .rel_req(rel_req), .rel_off(rel_off),
        .nmi(nmi), .irq(irq), .irq_mask(irq_mask), .vec_busy(vec_busy)
    );

    // pc block model, with a bench-side preset port
    logic        pc_set_en = 1'b0;
    logic [15:0] pc_set_val = 16'h0;
    always @(posedge clk) begin
        if (rst)            pc <= 16'h0;
        else if (pc_set_en) pc <= pc_set_val;
        else if (branch)    pc <= bra_add;
        else if (increment) pc <= pc + 16'h1;
    end

    logic [7:0] mem [logic [15:0]];
    function automatic logic [7:0] rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    int lat = 1;
    int wcnt = 0;
    int n_ack = 0;
    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
            wcnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            wcnt = 0;
        end else if (mem_req) begin
            wcnt++;
            if (wcnt >= lat) begin
                mem_ack = 1'b1;
                mem_data = rd(mem_addr);
                n_ack++;
            end
        end else begin
            wcnt = 0;
        end
    end

    int          n_br = 0, n_inc = 0, n_both = 0;
    logic [15:0] req_log [$];
    logic        req_prev = 1'b0;
    logic [15:0] addr_prev = 16'h0;
    always @(negedge clk) begin
        if (!rst) begin
            if (branch) n_br++;
            if (increment) n_inc++;
            if (branch && increment) n_both++;
            if (mem_req && (!req_prev || mem_addr != addr_prev))
                req_log.push_back(mem_addr);
        end
        req_prev = mem_req;
        addr_prev = mem_addr;
    end

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [15:0] logat(input int i);
        if (i >= 0 && i < req_log.size()) return req_log[i];
        return 16'hDEAD;
    endfunction

    task automatic wait_br(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (branch) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_req(input int n, input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (req_log.size() > n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic settle(output logic ok);
        int quiet;
        quiet = 0;
        ok = 1'b0;
        op_ready = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (op_valid && !mem_req && !increment && !branch && !vec_busy)
                quiet++;
            else
                quiet = 0;
            if (quiet >= 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_pc(input logic [15:0] v);
        pc_set_val = v;
        pc_set_en = 1'b1;
        @(negedge clk);
        pc_set_en = 1'b0;
    endtask

    task automatic redirect(input logic j, input logic r,
                            input logic [15:0] t, input logic [7:0] o);
        jmp_req = j;
        rel_req = r;
        jmp_target = t;
        rel_off = o;
        @(negedge clk);
        jmp_req = 1'b0;
        rel_req = 1'b0;
    endtask

    typedef struct {
        logic [15:0] pc;
        logic        j;
        logic        r;
        logic [15:0] tgt;
        logic [7:0]  off;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   sz, inc0, ack0, br0;

        tbl[0] = '{16'hFFF0, 1'b0, 1'b1, 16'h0000, 8'h20, 16'h0010};
        tbl[1] = '{16'h0005, 1'b0, 1'b1, 16'h0000, 8'hF0, 16'hFFF5};
        tbl[2] = '{16'h1000, 1'b0, 1'b1, 16'h0000, 8'h7F, 16'h107F};
        tbl[3] = '{16'h1000, 1'b0, 1'b1, 16'h0000, 8'h80, 16'h0F80};
        tbl[4] = '{16'h2000, 1'b1, 1'b0, 16'hABCD, 8'h00, 16'hABCD};
        tbl[5] = '{16'h3000, 1'b1, 1'b1, 16'h4000, 8'h05, 16'h4000};

        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        mem[16'h1234] = 8'hA9;
        mem[16'h1235] = 8'hEA;
        mem[16'hFFFA] = 8'h00;
        mem[16'hFFFB] = 8'h90;
        mem[16'hFFFE] = 8'h00;
        mem[16'hFFFF] = 8'hA0;
        mem[16'h6000] = 8'h11;
        mem[16'h6001] = 8'h22;

        rst = 1'b1;
        op_ready = 1'b0;
        jmp_req = 1'b0;
        rel_req = 1'b0;
        jmp_target = 16'h0;
        rel_off = 8'h0;
        nmi = 1'b0;
        irq = 1'b0;
        irq_mask = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_strobes", 32'({branch, increment, mem_req, op_valid, vec_busy}), 0);
        chk("rst_bra_add", 32'(bra_add), 0);
        chk("rst_addr_byte", 32'({mem_addr, op_byte}), 0);
        rst = 1'b0;

        // Boot: reset vector load
        wait_br(30, ok);
        chk("boot_br_seen", 32'(ok), 1);
        chk("boot_vec", 32'(bra_add), 'h1234);
        chk("boot_busy", 32'(vec_busy), 1);
        @(negedge clk);
        wait_req(2, 20, ok);
        chk("boot_req_lo", 32'(logat(0)), 'hFFFC);
        chk("boot_req_hi", 32'(logat(1)), 'hFFFD);
        chk("first_fetch", 32'(logat(2)), 'h1234);

        // Fetch with backpressure
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (op_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("fetch_valid", 32'(ok), 1);
        chk("fetch_byte", 32'(op_byte), 'hA9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
`ifdef PC_SEQ_PREFETCH_EN
            chk($sformatf("hold_%0d", i), 32'({op_valid, op_byte}), 'h1A9);
`else
            chk($sformatf("hold_%0d", i), 32'({op_valid, mem_req, op_byte}), 'h2A9);
`endif
        end
`ifndef PC_SEQ_PREFETCH_EN
        chk("hold_no_req", req_log.size(), 3);
        chk("single_inc", n_inc, 1);
        chk("pc_after_inc", 32'(pc), 'h1235);
`endif
        sz = req_log.size();
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        wait_req(sz, 20, ok);
`ifdef PC_SEQ_PREFETCH_EN
        chk("next_fetch", 32'(logat(sz)), 'h1236);
`else
        chk("next_fetch", 32'(logat(sz)), 'h1235);
`endif
        chk("boot_one_branch", n_br, 1);

        // Redirect table
        for (int k = 0; k < 6; k++) begin
            settle(ok);
            chk($sformatf("settle_%0d", k), 32'(ok), 1);
            set_pc(tbl[k].pc);
            redirect(tbl[k].j, tbl[k].r, tbl[k].tgt, tbl[k].off);
            wait_br(10, ok);
            chk($sformatf("redir_seen_%0d", k), 32'(ok), 1);
            chk($sformatf("redir_add_%0d", k), 32'(bra_add), 32'(tbl[k].exp));
            chk($sformatf("redir_flush_%0d", k), 32'(op_valid), 0);
            @(negedge clk);
        end

        // Jump while a fetch is outstanding
        settle(ok);
        set_pc(16'h5000);
        lat = 4;
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req && mem_addr == 16'h5000) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_req_seen", 32'(ok), 1);
        ack0 = n_ack;
        inc0 = n_inc;
        redirect(1'b1, 1'b0, 16'hC000, 8'h00);
        chk("mid_req_held", 32'({mem_req, mem_addr}), 'h15000);
        wait_br(20, ok);
        chk("mid_br_seen", 32'(ok), 1);
        chk("mid_br_add", 32'(bra_add), 'hC000);
        chk("mid_flush", 32'(op_valid), 0);
        sz = req_log.size();
        lat = 1;
        @(negedge clk);
        chk("mid_one_ack", n_ack - ack0, 1);
        chk("mid_no_inc", n_inc - inc0, 0);
        wait_req(sz, 20, ok);
        chk("mid_next_req", 32'(logat(sz)), 'hC000);

        // Masked irq is ignored
        op_ready = 1'b1;
        irq = 1'b1;
        irq_mask = 1'b1;
        br0 = n_br;
        repeat (20) @(negedge clk);
        chk("irq_masked", n_br - br0, 0);

        // NMI edge and unmasked irq together: NMI first, then irq
        nmi = 1'b1;
        irq_mask = 1'b0;
        wait_br(40, ok);
        chk("nmi_seen", 32'(ok), 1);
        chk("nmi_vec", 32'(bra_add), 'h9000);
        chk("nmi_busy", 32'(vec_busy), 1);
        sz = req_log.size();
        chk("nmi_reads", 32'({logat(sz - 2), logat(sz - 1)}), 'hFFFAFFFB);
        @(negedge clk);
        wait_br(40, ok);
        irq = 1'b0;
        chk("irq_seen", 32'(ok), 1);
        chk("irq_vec", 32'(bra_add), 'hA000);
        sz = req_log.size();
        chk("irq_reads", 32'({logat(sz - 2), logat(sz - 1)}), 'hFFFEFFFF);
        nmi = 1'b0;
        @(negedge clk);

`ifdef PC_SEQ_PREFETCH_EN
        // Two-deep prefetch keeps order and stalls when full
        settle(ok);
        redirect(1'b1, 1'b0, 16'h6000, 8'h00);
        wait_br(10, ok);
        chk("pf_br", 32'(bra_add), 'h6000);
        @(negedge clk);
        settle(ok);
        chk("pf_first", 32'({op_valid, op_byte}), 'h111);
        sz = req_log.size();
        repeat (5) @(negedge clk);
        chk("pf_stall", req_log.size() - sz, 0);
        chk("pf_reads", 32'({logat(sz - 2), logat(sz - 1)}), 'h60006001);
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        chk("pf_second", 32'({op_valid, op_byte}), 'h122);
        wait_req(sz, 20, ok);
        chk("pf_third_req", 32'(logat(sz)), 'h6002);
`endif

        chk("br_inc_exclusive", n_both, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
